sfp_packet_sender: RTL and testbench

- Sequences transmission of one packet from the on-chip packet RAM to the SFP MAC TX Avalon-ST interface.
- Triggered by a 0->1 transition of the host-controlled send command bit; the start word address comes from the same host register.
- Reads a header word giving the payload length, then streams the payload words with full Avalon-ST backpressure support.

---
 rtl/sfp_packet_sender_if.sv | 28 ++
 rtl/sfp_packet_sender.sv | 166 ++++++++++++++++
 tb/tb_sfp_packet_sender.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sfp_packet_sender_if.sv
// RAM read port and Avalon-ST TX stream of the SFP packet sender.
interface sfp_packet_sender_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (
        output ram_rd_en, ram_rd_addr,
        input  ram_rd_data,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  ram_rd_en, ram_rd_addr,
        output ram_rd_data,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );
endinterface

// File: rtl/sfp_packet_sender.sv
// Streams one packet (header word = length, then payload) from packet RAM to the SFP MAC TX.
// Define SFP_SEND_STATS_EN to add the pkt_cnt/drop_cnt statistics outputs.
module sfp_packet_sender #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                send_cmd,
    input  logic [ADDR_W-1:0]   start_ram_addr,
    sfp_packet_sender_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                err_len
`ifdef SFP_SEND_STATS_EN
    ,
    output logic [15:0]         pkt_cnt,
    output logic [15:0]         drop_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, HDR_RD, HDR_WAIT, STREAM, DONE} state_t;
    localparam logic [ADDR_W-1:0] ONE = 1;

    state_t            state_q;
    logic              send_cmd_q, send_cmd_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] base_q, base_d, len_q, len_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_cnt_q, rd_cnt_d, beat_q, beat_d;
    logic              rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              start, st_valid_w, pop, last_beat, rd_issue;
    logic [ADDR_W-1:0] hdr_len, len_m1;
    logic [2:0]        occ;

    always_comb begin
        start      = send_cmd & ~send_cmd_q;
        hdr_len    = bus.ram_rd_data[ADDR_W-1:0];
        len_m1     = len_q - ONE;
        st_valid_w = (cnt_q != 2'd0);
        pop        = st_valid_w & bus.st_ready;
        last_beat  = pop && (beat_q == len_m1);
        // Counting this cycle's pop keeps one beat per cycle without ever overfilling the FIFO.
        occ        = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
        rd_issue   = (state_q == STREAM) && (rd_cnt_q != len_q) && (occ < 3'd2);
    end

    always_comb begin
        send_cmd_d = send_cmd;
        busy_d     = busy_q;
        base_d     = base_q;
        len_d      = len_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        beat_d     = beat_q;
        rd_vld_d   = rd_issue;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q + 2'(rd_vld_q) - 2'(pop);
        if (state_q == IDLE && start) begin
            base_d = start_ram_addr;
            busy_d = 1'b1;
        end
        if (state_q == HDR_WAIT) begin
            len_d     = hdr_len;
            rd_addr_d = base_q + ONE;
            rd_cnt_d  = '0;
            beat_d    = '0;
            if (hdr_len == '0) busy_d = 1'b0;
        end
        if (state_q == DONE) busy_d = 1'b0;
        if (rd_issue) begin
            rd_addr_d = rd_addr_q + ONE;
            rd_cnt_d  = rd_cnt_q + ONE;
        end
        if (rd_vld_q) begin
            fifo_d[wr_ptr_q] = bus.ram_rd_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            beat_d   = beat_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:     if (start) state_q <= HDR_RD;
                HDR_RD:   state_q <= HDR_WAIT;
                HDR_WAIT: state_q <= (hdr_len == '0) ? IDLE : STREAM;
                STREAM:   if (last_beat) state_q <= DONE;
                DONE:     state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_cmd_q <= 1'b1;  // a level already high at reset release is not an edge
            busy_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            beat_q     <= '0;
            rd_vld_q   <= 1'b0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            send_cmd_q <= send_cmd_d;
            busy_q     <= busy_d;
            base_q     <= base_d;
            len_q      <= len_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_q     <= beat_d;
            rd_vld_q   <= rd_vld_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ram_rd_en   = (state_q == HDR_RD) || rd_issue;
    assign bus.ram_rd_addr = (state_q == HDR_RD) ? base_q : (rd_issue ? rd_addr_q : '0);
    assign bus.st_valid    = st_valid_w;
    assign bus.st_data     = st_valid_w ? fifo_q[rd_ptr_q] : '0;
    assign bus.st_sop      = st_valid_w && (beat_q == '0);
    assign bus.st_eop      = st_valid_w && (beat_q == len_m1);
    assign busy            = busy_q;
    assign done            = (state_q == DONE);
    assign err_len         = (state_q == HDR_WAIT) && (hdr_len == '0);

`ifdef SFP_SEND_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + 16'(done);
        drop_cnt_d = drop_cnt_q + 16'(start & busy_q) + 16'(err_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_sfp_packet_sender.sv
// Randomized bench for sfp_packet_sender: RAM model, packet-level reference and stream monitor.
module tb_sfp_packet_sender;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          send_cmd = 1'b1;
    logic [AW-1:0] start_ram_addr = '0;
    logic          busy, done, err_len;
`ifdef SFP_SEND_STATS_EN
    logic [15:0]   pkt_cnt, drop_cnt;
`endif
    logic [DW-1:0] ram [64];
    int total = 0;
    int bad = 0;
    int exp_pkt = 0;
    int exp_drop = 0;

    sfp_packet_sender_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    sfp_packet_sender #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .send_cmd       (send_cmd),
        .start_ram_addr (start_ram_addr),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .err_len        (err_len)
`ifdef SFP_SEND_STATS_EN
        ,
        .pkt_cnt        (pkt_cnt),
        .drop_cnt       (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Packet RAM: data appears exactly one cycle after the read strobe.
    always @(posedge clk) if (bus.ram_rd_en) bus.ram_rd_data <= ram[bus.ram_rd_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.ram_rd_en, bus.st_valid, bus.st_sop, bus.st_eop, busy, done, err_len,
                    bus.st_data, bus.ram_rd_addr});
    endfunction

    function automatic logic rdy(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       case (cyc % 6) 0, 3, 5: return 1'b1; default: return 1'b0; endcase
            default: return ($urandom % 3) != 0;
        endcase
    endfunction

    task automatic check_stats();
`ifdef SFP_SEND_STATS_EN
        chk("pkt_cnt", pkt_cnt, exp_pkt);
        chk("drop_cnt", drop_cnt, exp_drop);
`endif
    endtask

    // Launch one packet at base and compare everything seen against the RAM contents.
    task automatic run_pkt(input logic [AW-1:0] base, input int rmode, input bit retrig);
        logic [AW-1:0] n, a;
        logic [DW-1:0] exp_q[$];
        logic [AW-1:0] addr_q[$];
        logic [AW-1:0] obs_q[$];
        logic [DW+1:0] held = '0;
        int beats = 0, dones = 0, errs = 0, busy_cyc = 0;
        int end_cyc = -1, first_cyc = -1, rd_first = -1, cyc = 0;
        bit stall = 0, vseen = 0;
        n = ram[base][AW-1:0];
        addr_q.push_back(base);
        for (int k = 1; k <= int'(n); k++) begin
            a = base + AW'(k);
            addr_q.push_back(a);
            exp_q.push_back(ram[a]);
        end
        @(posedge clk); #1;
        start_ram_addr = base;
        send_cmd = 1'b1;
        bus.st_ready = rdy(rmode, 0);
        while (cyc < 400) begin
            @(negedge clk);
            if (bus.ram_rd_en) begin
                if (rd_first < 0) rd_first = cyc;
                obs_q.push_back(bus.ram_rd_addr);
            end
            if (busy) busy_cyc++;
            if (bus.st_valid) vseen = 1;
            if (stall) chk("hold", {bus.st_valid, bus.st_sop, bus.st_eop, bus.st_data}, {1'b1, held});
            if (bus.st_valid && bus.st_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (beats < exp_q.size()) chk("beat_data", bus.st_data, exp_q[beats]);
                else chk("extra_beat", 1, 0);
                chk("sop", bus.st_sop, beats == 0);
                chk("eop", bus.st_eop, beats == int'(n) - 1);
                beats++;
            end
            stall = bus.st_valid && !bus.st_ready;
            held = {bus.st_sop, bus.st_eop, bus.st_data};
            if (done) begin dones++; end_cyc = cyc; end
            if (err_len) begin errs++; end_cyc = cyc; end
            if (end_cyc >= 0 && cyc == end_cyc + 2) break;
            @(posedge clk); #1;
            cyc++;
            bus.st_ready = rdy(rmode, cyc);
            if (cyc == 1) send_cmd = 1'b0;
            if (retrig && cyc == 3) begin send_cmd = 1'b1; start_ram_addr = base + AW'(7); end
            if (retrig && cyc == 5) send_cmd = 1'b0;
        end
        chk("timeout", end_cyc >= 0, 1);
        chk("beats", beats, n);
        chk("dones", dones, n != 0);
        chk("errs", errs, n == 0);
        chk("hdr_cyc", rd_first, 1);
        chk("busy_cyc", busy_cyc, end_cyc);
        chk("rd_cnt", obs_q.size(), int'(n) + 1);
        for (int i = 0; i < obs_q.size() && i < addr_q.size(); i++) chk("rd_addr", obs_q[i], addr_q[i]);
        if (n == 0) begin
            chk("err_cyc", end_cyc, 2);
            chk("no_valid", vseen, 0);
            exp_drop++;
        end else begin
            exp_pkt++;
            if (rmode == 0) begin
                chk("first_beat", first_cyc, 5);
                chk("done_cyc", end_cyc, int'(n) + 5);
            end
        end
        if (retrig) exp_drop++;
        check_stats();
    endtask

    initial begin
        logic [AW-1:0] b, n;
        int beats, cyc;
        for (int i = 0; i < 64; i++) ram[i] = '0;
        bus.st_ready = 1'b1;
        #2;
        chk("rst_outs", outs(), 0);
        check_stats();
        #10 rst_n = 1'b1;
        // send_cmd held high across reset release must not start a packet
        repeat (3) @(negedge clk);
        chk("no_start_busy", busy, 0);
        chk("no_start_outs", outs(), 0);
        @(posedge clk); #1 send_cmd = 1'b0;

        ram[4] = 32'd3; ram[5] = 32'hA1; ram[6] = 32'hA2; ram[7] = 32'hA3;
        run_pkt(6'd4, 0, 0);
        run_pkt(6'd4, 1, 0);
        ram[10] = 32'h0000_0F40;
        run_pkt(6'd10, 0, 0);
        ram[62] = 32'd3; ram[63] = 32'hB0; ram[0] = 32'hB1; ram[1] = 32'hB2;
        run_pkt(6'd62, 0, 0);
        ram[20] = 32'hFFFF_FFC1; ram[21] = 32'hC0;
        run_pkt(6'd20, 0, 0);
        ram[40] = 32'd4; ram[41] = 32'hD0; ram[42] = 32'hD1; ram[43] = 32'hD2; ram[44] = 32'hD3;
        run_pkt(6'd40, 0, 1);

        for (int t = 0; t < 14; t++) begin
            b = AW'($urandom);
            n = AW'($urandom % 9);
            ram[b] = ($urandom & ~32'h3F) | 32'(n);
            for (int k = 1; k <= int'(n); k++) ram[b + AW'(k)] = $urandom;
            run_pkt(b, int'($urandom % 3), (n != 0) && ($urandom % 2 == 1));
        end

        // Reset in the middle of a 5-word packet
        ram[30] = 32'd5;
        for (int k = 31; k <= 35; k++) ram[k] = 32'hE0 + 32'(k);
        @(posedge clk); #1;
        start_ram_addr = 6'd30; send_cmd = 1'b1; bus.st_ready = 1'b1;
        beats = 0; cyc = 0;
        while (beats < 2 && cyc < 50) begin
            @(negedge clk);
            if (bus.st_valid && bus.st_ready) beats++;
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) send_cmd = 1'b0;
        end
        chk("rst_two_beats", beats, 2);
        #1 rst_n = 1'b0;
        #1 chk("midrst_outs", outs(), 0);
        exp_pkt = 0; exp_drop = 0;
        check_stats();
        @(negedge clk);
        chk("midrst_hold", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", outs(), 0);
        run_pkt(6'd30, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
